// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencer for a combinational InsMem, feeding decode through a small prefetch queue
module ifetch_ctrl #(
    parameter int PC_W     = 16,
    parameter int INSN_W   = 32,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [PC_W-1:0]   imem_pc,
    input  logic [INSN_W-1:0] imem_insn,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic              busy
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic {IDLE, FETCH} state_t;
    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_pc_q   [DEPTH];
    logic [INSN_W-1:0]   r_insn_q [DEPTH];
    logic [AW-1:0]       r_rd, r_wr;
    logic [CW-1:0]       r_cnt;
    logic                w_pop, w_push;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        w_next = r_state;
        w_next = run ? FETCH : IDLE;
    end
    assign out_valid = r_cnt != '0;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = (r_state == FETCH) & run & !redirect_valid & ((r_cnt < CW'(DEPTH)) | w_pop);
    assign out_insn  = r_insn_q[r_rd];
    assign out_pc    = r_pc_q[r_rd];
    assign imem_pc   = r_pc;
    assign busy      = (r_state == FETCH) | out_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= PC_W'(RESET_PC);
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_q[i]   <= '0;
                r_insn_q[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            // redirect discards the queue; a concurrent pop was already accepted by decode
            if (redirect_valid) begin
                r_pc  <= redirect_pc;
                r_wr  <= r_rd;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_pc_q[r_wr]   <= r_pc;
                    r_insn_q[r_wr] <= imem_insn;
                    r_wr           <= inc(r_wr);
                    r_pc           <= r_pc + PC_W'(PC_STEP);
                end
                if (w_pop) r_rd <= inc(r_rd);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenario tests for ifetch_ctrl with InsMem modelled as mem[i] = A000_0000 + i
module tb_ifetch_ctrl;
    logic        clk = 0, rst_n = 0, run = 0, redirect_valid = 0, out_ready = 0;
    logic [15:0] imem_pc, redirect_pc = '0, out_pc;
    logic [31:0] imem_insn, out_insn;
    logic        out_valid, busy;
    int errors = 0, checks = 0;

    ifetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_pc(imem_pc), .imem_insn(imem_insn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc), .busy(busy)
    );

    assign imem_insn = 32'hA000_0000 + {16'h0, imem_pc};
    always #5 clk = ~clk;

    task automatic do_reset();
        run = 0; out_ready = 0; redirect_valid = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (imem_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0000", imem_pc); end
        checks++; if (out_pc !== 16'h0 || out_insn !== 32'h0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0000/00000000", out_pc, out_insn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1;
    endtask

    task automatic test_stream();
        do_reset();
        run = 1; out_ready = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stream_entry valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_insn !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL stream_%0d got v=%b pc=%h insn=%h exp v=1 pc=%h insn=%h", i, out_valid, out_pc, out_insn, 16'(i), 32'hA000_0000 + i);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run = 1; out_ready = 0;
        repeat (7) @(negedge clk);
        checks++; if (imem_pc !== 16'h2) begin errors++; $display("FAIL stall_pc got=%h exp=0002", imem_pc); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0 || out_insn !== 32'hA000_0000) begin errors++; $display("FAIL stall_head got v=%b pc=%h insn=%h exp v=1 pc=0000 insn=a0000000", out_valid, out_pc, out_insn); end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_insn !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL stall_drain_%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 16'(i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run = 1; out_ready = 0;
        repeat (4) @(negedge clk);
        out_ready = 1; redirect_valid = 1; redirect_pc = 16'h0040;
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0) begin errors++; $display("FAIL redir_pop got v=%b pc=%h exp v=1 pc=0000", out_valid, out_pc); end
        @(negedge clk); redirect_valid = 0;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 16'h0040) begin errors++; $display("FAIL redir_flush got v=%b imem_pc=%h exp v=0 imem_pc=0040", out_valid, imem_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_insn !== 32'hA000_0040) begin errors++; $display("FAIL redir_target got v=%b pc=%h insn=%h exp v=1 pc=0040 insn=a0000040", out_valid, out_pc, out_insn); end
        @(negedge clk);
        checks++; if (out_pc !== 16'h0041) begin errors++; $display("FAIL redir_next got=%h exp=0041", out_pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
        redirect_valid = 1; redirect_pc = 16'hFFFF;
        @(negedge clk); redirect_valid = 0;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_flush got v=%b imem_pc=%h exp v=0 imem_pc=ffff", out_valid, imem_pc); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_insn !== 32'hA000_0000 + {16'h0, exp_pc[i]}) begin
                errors++; $display("FAIL wrap_%0d got v=%b pc=%h insn=%h exp v=1 pc=%h", i, out_valid, out_pc, out_insn, exp_pc[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_idle();
        do_reset();
        run = 1; out_ready = 0;
        repeat (4) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        checks++; if (imem_pc !== 16'h2 || out_valid !== 1'b1) begin errors++; $display("FAIL idle_hold got imem_pc=%h v=%b exp 0002 v=1", imem_pc, out_valid); end
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 16'(i)) begin errors++; $display("FAIL idle_drain_%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 16'(i)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || imem_pc !== 16'h2) begin errors++; $display("FAIL idle_empty got v=%b busy=%b imem_pc=%h exp v=0 busy=0 imem_pc=0002", out_valid, busy, imem_pc); end
        run = 1;
        @(negedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h2 || out_insn !== 32'hA000_0002) begin errors++; $display("FAIL idle_resume got v=%b pc=%h insn=%h exp v=1 pc=0002 insn=a0000002", out_valid, out_pc, out_insn); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1; out_ready = 1;
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst got v=%b imem_pc=%h busy=%b exp v=0 imem_pc=0000 busy=0", out_valid, imem_pc, busy); end
        @(negedge clk); rst_n = 1;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 16'(i)) begin errors++; $display("FAIL async_restart_%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 16'(i)); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_run_idle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
